// File: rtl/nn_fp_pkg.sv
// Shared FP32 field constants, classification helpers and the relu backward FSM encoding.
package nn_fp_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_W    = 23;

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

    localparam logic ENC_FILL  = 1'b0;
    localparam logic ENC_DRAIN = 1'b1;

    typedef enum logic {
        FILL  = ENC_FILL,
        DRAIN = ENC_DRAIN
    } state_t;

    function automatic logic is_nan(input logic [31:0] v);
        return (&v[EXP_MSB:EXP_LSB]) && (|v[MAN_W-1:0]);
    endfunction

    // Both +0 and -0 count as zero.
    function automatic logic is_zero(input logic [31:0] v);
        return ~|v[EXP_MSB:0];
    endfunction

endpackage

// File: rtl/relu_backprop_if.sv
// Bus between the gradient source / forward capture side and relu_backprop, plus debug taps.
interface relu_backprop_if
    import nn_fp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int PTR_W = $clog2(DEPTH);

    // Strobes are valid-only: fwd_rdy/bwd_rdy mark a word present this cycle and
    // there is no backpressure; done/layer_done are single-cycle result strobes.
    logic              fwd_rdy;
    logic [DATA_W-1:0] fwd_x;
    logic              bwd_rdy;
    logic [DATA_W-1:0] bwd_grad;
    logic [DATA_W-1:0] dx_data;
    logic              done;
    logic              layer_done;
    logic              full;
    logic              err;
    state_t            dbg_state;
    logic [PTR_W-1:0]  dbg_wptr;
    logic [PTR_W-1:0]  dbg_rptr;

    modport master (
        output fwd_rdy, fwd_x, bwd_rdy, bwd_grad,
        input  dx_data, done, layer_done, full, err, dbg_state, dbg_wptr, dbg_rptr
    );

    modport slave (
        input  fwd_rdy, fwd_x, bwd_rdy, bwd_grad,
        output dx_data, done, layer_done, full, err, dbg_state, dbg_wptr, dbg_rptr
    );

endinterface

// File: rtl/relu_bwd_gate.sv
// Combinational relu'(x) gate on an FP32 gradient. Leaky slope enabled by RELU_BWD_LEAKY_EN.
module relu_bwd_gate
    import nn_fp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LEAK_SHIFT = 7
) (
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_g,
    output logic [DATA_W-1:0] o_dx
);

    if (DATA_W != 32 || LEAK_SHIFT < 0 || LEAK_SHIFT > 254) begin : g_param_chk
        $error("relu_bwd_gate: DATA_W must be 32 and LEAK_SHIFT within 0..254");
    end

    logic w_x_pos;
    assign w_x_pos = !i_x[SIGN_BIT] && !is_zero(i_x) && !is_nan(i_x);

`ifdef RELU_BWD_LEAKY_EN
    logic       w_x_neg;
    logic [7:0] w_exp_dec;
    assign w_x_neg   = i_x[SIGN_BIT] && !is_zero(i_x) && !is_nan(i_x);
    assign w_exp_dec = i_g[EXP_MSB:EXP_LSB] - 8'(LEAK_SHIFT);
`endif

    always_comb begin
        o_dx = FP_POS_ZERO;
        if (w_x_pos) begin
            o_dx = i_g;
        end
`ifdef RELU_BWD_LEAKY_EN
        else if (w_x_neg) begin
            // Scale by 2^-LEAK_SHIFT through the exponent; flush to signed zero on underflow.
            if (&i_g[EXP_MSB:EXP_LSB]) begin
                o_dx = i_g;
            end else if (i_g[EXP_MSB:EXP_LSB] <= 8'(LEAK_SHIFT)) begin
                o_dx = {i_g[SIGN_BIT], 31'b0};
            end else begin
                o_dx = {i_g[SIGN_BIT], w_exp_dec, i_g[MAN_W-1:0]};
            end
        end
`endif
    end

endmodule

// File: rtl/relu_backprop.sv
// ReLU backward unit: stores one layer of pre-activations, then gates gradients by relu'(x).
// Optional leaky slope via RELU_BWD_LEAKY_EN (handled inside relu_bwd_gate).
module relu_backprop
    import nn_fp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int LEAK_SHIFT = 7
) (
    input logic           clk,
    input logic           rst_n,
    relu_backprop_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [DATA_W-1:0] r_dx;
    logic              r_done;
    logic              r_layer_done;
    logic              r_full;
    logic              r_err;

    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_err_set;
    logic              w_last_wr;
    logic              w_last_rd;
    logic [DATA_W-1:0] w_dx;

    relu_bwd_gate #(
        .DATA_W     (DATA_W),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_gate (
        .i_x  (r_mem[r_rptr]),
        .i_g  (bus.bwd_grad),
        .o_dx (w_dx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_err_set   = 1'b0;
        w_last_wr   = 1'b0;
        w_last_rd   = 1'b0;
        case (r_state)
            FILL: begin
                w_wr_en   = bus.fwd_rdy;
                w_err_set = bus.bwd_rdy;
                w_last_wr = bus.fwd_rdy && (r_wptr == LAST_IDX);
                if (w_last_wr) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // A stray forward word is dropped but the gradient is still serviced.
                w_rd_en   = bus.bwd_rdy;
                w_err_set = bus.fwd_rdy;
                w_last_rd = bus.bwd_rdy && (r_rptr == LAST_IDX);
                if (w_last_rd) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FILL;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_dx         <= '0;
            r_done       <= 1'b0;
            r_layer_done <= 1'b0;
            r_full       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_done       <= w_rd_en;
            r_layer_done <= w_last_rd;
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + 1'b1;
                r_dx   <= w_dx;
            end
            if (w_last_wr) begin
                r_full <= 1'b1;
            end else if (w_last_rd) begin
                r_full <= 1'b0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: a reset clears the pointers, which forces a refill.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= bus.fwd_x;
        end
    end

    assign bus.dx_data    = r_dx;
    assign bus.done       = r_done;
    assign bus.layer_done = r_layer_done;
    assign bus.full       = r_full;
    assign bus.err        = r_err;
    assign bus.dbg_state  = r_state;
    assign bus.dbg_wptr   = r_wptr;
    assign bus.dbg_rptr   = r_rptr;

endmodule

// File: tb/tb_relu_backprop.sv
// Directed table-driven bench for relu_backprop; honours RELU_BWD_LEAKY_EN for expected values.
module tb_relu_backprop;
  import nn_fp_pkg::*;

  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] x;
    logic [31:0] g;
    logic [31:0] dx;
  } vec_t;

`ifdef RELU_BWD_LEAKY_EN
  localparam bit LEAKY = 1'b1;
`else
  localparam bit LEAKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  relu_backprop_if #(.DATA_W(32), .DEPTH(DEPTH)) bus ();

  relu_backprop #(.DATA_W(32), .DEPTH(DEPTH), .LEAK_SHIFT(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vec_t tbl[DEPTH];
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // id 0: positive x; 1: negative x; 2: mixed classes and leaky corners.
  task automatic load_tbl(input int id);
    vec_t c[DEPTH];
    c[0]  = '{32'h0000_0000, 32'hbf80_0000, 32'h0000_0000};
    c[1]  = '{32'h8000_0000, 32'hbf80_0000, 32'h0000_0000};
    c[2]  = '{32'h7fc0_0000, 32'hbf80_0000, 32'h0000_0000};
    c[3]  = '{32'h0000_0001, 32'hbf80_0000, 32'hbf80_0000};
    c[4]  = '{32'h7f80_0000, 32'h1234_5678, 32'h1234_5678};
    c[5]  = '{32'hff80_0000, 32'h3f80_0000, LEAKY ? 32'h3c00_0000 : 32'h0};
    c[6]  = '{32'hffc0_0001, 32'h3f80_0000, 32'h0000_0000};
    c[7]  = '{32'hbf80_0000, 32'h7f80_0000, LEAKY ? 32'h7f80_0000 : 32'h0};
    c[8]  = '{32'h8000_0001, 32'h0400_0000, LEAKY ? 32'h0080_0000 : 32'h0};
    c[9]  = '{32'h8000_0001, 32'h8380_0000, LEAKY ? 32'h8000_0000 : 32'h0};
    c[10] = '{32'h7f7f_ffff, 32'hffff_ffff, 32'hffff_ffff};
    c[11] = '{32'h3f80_0000, 32'h8000_0000, 32'h8000_0000};
    c[12] = '{32'h7f80_0001, 32'h3f80_0000, 32'h0000_0000};
    c[13] = '{32'h0080_0000, 32'h0000_0001, 32'h0000_0001};
    c[14] = '{32'hc2c8_0000, 32'hc120_0000, LEAKY ? 32'hbda0_0000 : 32'h0};
    c[15] = '{32'h4000_0000, 32'ha5a5_a5a5, 32'ha5a5_a5a5};
    for (int k = 0; k < DEPTH; k++) begin
      case (id)
        0:       tbl[k] = '{32'h4105_47ae, 32'h3f80_0000, 32'h3f80_0000};
        1:       tbl[k] = '{32'hc0e8_0000, 32'h4040_0000, LEAKY ? 32'h3cc0_0000 : 32'h0};
        default: tbl[k] = c[k];
      endcase
    end
  endtask

  task automatic fill_layer();
    for (int k = 0; k < DEPTH; k++) begin
      bus.fwd_rdy = 1'b1;
      bus.fwd_x   = tbl[k].x;
      tick();
      check("fill_wptr", 32'(bus.dbg_wptr), 32'((k + 1) % DEPTH));
      check("fill_full", 32'(bus.full), 32'(k == DEPTH - 1));
      check("fill_state", 32'(bus.dbg_state), 32'((k == DEPTH - 1) ? DRAIN : FILL));
    end
    bus.fwd_rdy = 1'b0;
  endtask

  task automatic drain_layer(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      bus.bwd_rdy  = 1'b1;
      bus.bwd_grad = tbl[k].g;
      exp_q.push_back(tbl[k].dx);
      tick();
      check("drain_done", 32'(bus.done), 32'd1);
      check("drain_dx", bus.dx_data, exp_q.pop_front());
      check("drain_layer_done", 32'(bus.layer_done), 32'(k == DEPTH - 1));
      check("drain_full", 32'(bus.full), 32'(k != DEPTH - 1));
    end
    bus.bwd_rdy = 1'b0;
  endtask

  initial begin
    bus.fwd_rdy  = 1'b0;
    bus.fwd_x    = '0;
    bus.bwd_rdy  = 1'b0;
    bus.bwd_grad = '0;
    #12;
    check("rst_dx", bus.dx_data, 32'h0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_layer_done", 32'(bus.layer_done), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(FILL));
    rst_n = 1'b1;
    tick();

    // Positive x passes gradients; then an idle cycle must not pulse done and dx holds.
    load_tbl(0);
    fill_layer();
    drain_layer(0, DEPTH - 1);
    tick();
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_layer_done", 32'(bus.layer_done), 32'd0);
    check("idle_dx_hold", bus.dx_data, 32'h3f80_0000);

    // Negative x, then refill straight after the last read (fill checks wptr==1 first).
    load_tbl(1);
    fill_layer();
    drain_layer(0, DEPTH - 1);
    load_tbl(2);
    fill_layer();
    drain_layer(0, DEPTH - 1);
    check("no_err_yet", 32'(bus.err), 32'd0);

    // Protocol violations.
    tick();
    bus.bwd_rdy  = 1'b1;
    bus.bwd_grad = 32'h3f80_0000;
    tick();
    bus.bwd_rdy = 1'b0;
    check("bwd_in_fill_err", 32'(bus.err), 32'd1);
    check("bwd_in_fill_done", 32'(bus.done), 32'd0);
    check("bwd_in_fill_wptr", 32'(bus.dbg_wptr), 32'd0);
    check("bwd_in_fill_rptr", 32'(bus.dbg_rptr), 32'd0);
    check("bwd_in_fill_dx", bus.dx_data, tbl[DEPTH-1].dx);
    load_tbl(0);
    fill_layer();
    bus.fwd_rdy = 1'b1;
    bus.fwd_x   = 32'hdead_beef;
    tick();
    check("fwd_in_drain_err", 32'(bus.err), 32'd1);
    check("fwd_in_drain_done", 32'(bus.done), 32'd0);
    check("fwd_in_drain_wptr", 32'(bus.dbg_wptr), 32'd0);
    check("fwd_in_drain_rptr", 32'(bus.dbg_rptr), 32'd0);
    check("fwd_in_drain_full", 32'(bus.full), 32'd1);
    bus.bwd_rdy  = 1'b1;
    bus.bwd_grad = tbl[0].g;
    tick();
    bus.fwd_rdy = 1'b0;
    bus.bwd_rdy = 1'b0;
    check("both_done", 32'(bus.done), 32'd1);
    check("both_dx", bus.dx_data, tbl[0].dx);
    check("both_rptr", 32'(bus.dbg_rptr), 32'd1);
    check("both_wptr", 32'(bus.dbg_wptr), 32'd0);
    drain_layer(1, DEPTH - 1);
    check("err_sticky", 32'(bus.err), 32'd1);

    // Reset in the middle of a drain.
    load_tbl(2);
    fill_layer();
    drain_layer(0, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_dx", bus.dx_data, 32'h0);
    check("mid_rst_full", 32'(bus.full), 32'd0);
    check("mid_rst_err", 32'(bus.err), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_state", 32'(bus.dbg_state), 32'(FILL));
    check("mid_rst_rptr", 32'(bus.dbg_rptr), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    load_tbl(1);
    fill_layer();
    drain_layer(0, DEPTH - 1);
    check("final_err", 32'(bus.err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
